isp_dram_reader: RTL



---
 rtl/isp_pkg.sv | 45 ++++
 rtl/isp_beat_fifo.sv | 76 +++++++
 rtl/isp_dram_reader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/isp_pkg.sv
// Shared constants, channel encoding and address/channel helpers for the ISP DRAM picture reader.
package isp_pkg;

  localparam logic [31:0] BASE_ADDR      = 32'h0001_0000;
  localparam logic [31:0] PIC_BYTES      = 32'd3072;
  localparam int          BEATS          = 192;
  localparam logic [7:0]  CHAN_BEATS     = 8'd64;
  localparam logic [7:0]  LAST_IDX       = 8'(BEATS - 1);
  localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    CHAN_R = 2'd0,
    CHAN_G = 2'd1,
    CHAN_B = 2'd2
  } chan_e;

  typedef struct packed {
    logic [7:0]   idx;
    logic [127:0] data;
  } beat_t;

  function automatic logic [31:0] pic_addr(input logic [3:0] pic);
    return BASE_ADDR + PIC_BYTES * {28'd0, pic};
  endfunction

  // Pictures are stored as planar R, G, B thirds of CHAN_BEATS beats each.
  function automatic logic [1:0] chan_of(input logic [7:0] idx);
    logic [1:0] chan;
    if (idx < CHAN_BEATS) begin
      chan = CHAN_R;
    end else if (idx < (CHAN_BEATS << 1)) begin
      chan = CHAN_G;
    end else begin
      chan = CHAN_B;
    end
    return chan;
  endfunction

endpackage

// File: rtl/isp_beat_fifo.sv
// Small registered FIFO holding {index, data} beats between the AXI read channel and the core.
module isp_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 136
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/isp_dram_reader.sv
// Fetches one picture from DRAM as a single 192-beat AXI4 INCR burst and streams the beats,
// tagged with index/channel/last, to the ISP core through a small FIFO.
module isp_dram_reader
  import isp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [3:0]   req_pic_no,
  output logic         req_ready,
  output logic [3:0]   arid_s_inf,
  output logic [31:0]  araddr_s_inf,
  output logic [7:0]   arlen_s_inf,
  output logic [2:0]   arsize_s_inf,
  output logic [1:0]   arburst_s_inf,
  output logic         arvalid_s_inf,
  input  logic         arready_s_inf,
  input  logic [3:0]   rid_s_inf,
  input  logic [127:0] rdata_s_inf,
  input  logic [1:0]   rresp_s_inf,
  input  logic         rlast_s_inf,
  input  logic         rvalid_s_inf,
  output logic         rready_s_inf,
  output logic         beat_valid,
  input  logic         beat_ready,
  output logic [127:0] beat_data,
  output logic [7:0]   beat_idx,
  output logic [1:0]   beat_chan,
  output logic         beat_last,
  output logic         busy,
  output logic         err
);

  logic [1:0]                  state_q, state_d;
  logic [31:0]                 araddr_q, araddr_d;
  logic [7:0]                  rcnt_q, rcnt_d;
  logic                        err_q, err_d;
  logic                        push_s, pop_s;
  logic                        fifo_full_s, fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  beat_t                       push_beat_s, head_s;
  logic                        unused_s;

  assign unused_s = ^{rid_s_inf, fifo_count_s};

  // rready depends only on registered state, never on the downstream ready.
  assign rready_s_inf  = (state_q == ST_DATA) && !fifo_full_s;
  assign push_s        = rvalid_s_inf && rready_s_inf;
  assign pop_s         = beat_valid && beat_ready;
  assign push_beat_s   = '{idx: rcnt_q, data: rdata_s_inf};

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;
  assign arvalid_s_inf = (state_q == ST_ADDR);
  assign araddr_s_inf  = araddr_q;
  assign arid_s_inf    = 4'd0;
  assign arlen_s_inf   = LAST_IDX;
  assign arsize_s_inf  = AXI_SIZE_16B;
  assign arburst_s_inf = AXI_BURST_INCR;

  assign beat_valid    = !fifo_empty_s;
  assign beat_data     = head_s.data;
  assign beat_idx      = head_s.idx;
  assign beat_chan     = chan_of(head_s.idx);
  assign beat_last     = (head_s.idx == LAST_IDX);

  isp_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_beat_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Fetch sequencer; the burst length is enforced by count, rlast is only cross-checked.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    rcnt_d   = rcnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          araddr_d = pic_addr(req_pic_no);
          rcnt_d   = 8'd0;
          err_d    = 1'b0;
          state_d  = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (arready_s_inf) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (push_s) begin
          rcnt_d = rcnt_q + 8'd1;
          if (rresp_s_inf != 2'b00) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (rcnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
            if (!rlast_s_inf) begin
              err_d = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else if (rlast_s_inf) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      araddr_q <= 32'd0;
      rcnt_q   <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      rcnt_q   <= rcnt_d;
      err_q    <= err_d;
    end
  end

endmodule
